// File: rtl/dm_unloader_pkg.sv
// Shared definitions for the DM-to-MEMORY unload path (also used by top).
package dm_unloader_pkg;

  localparam int unsigned DM_DATA_SIZE = 32;
  localparam int unsigned DM_ADDR_SIZE = 12;
  localparam int unsigned DM_MEM_SIZE  = 14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } unload_state_t;

endpackage

// File: rtl/dm_unloader.sv
// Copies a contiguous range of DM words to external MEMORY, two cycles per word.
module dm_unloader
  import dm_unloader_pkg::*;
#(
  parameter int unsigned DataSize   = DM_DATA_SIZE,
  parameter int unsigned DMAddrSize = DM_ADDR_SIZE,
  parameter int unsigned MEMSize    = DM_MEM_SIZE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DMAddrSize-1:0] src_base,
  input  logic [MEMSize-1:0]    dst_base,
  input  logic [DMAddrSize:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [DMAddrSize:0]   words_done,
  output logic                  DM_enable,
  output logic                  DM_read,
  output logic                  DM_write,
  output logic [DMAddrSize-1:0] DM_address,
  input  logic [DataSize-1:0]   DM_out,
  output logic                  MEM_en,
  output logic                  MEM_write,
  output logic                  MEM_read,
  output logic [MEMSize-1:0]    MEM_addr,
  output logic [DataSize-1:0]   MEM_Din
);

  localparam int unsigned CntW = DMAddrSize + 1;

  unload_state_t         state_q, state_d;
  logic [DMAddrSize-1:0] src_ptr_q;
  logic [MEMSize-1:0]    dst_ptr_q;
  logic [CntW-1:0]       remaining_q;
  logic [CntW-1:0]       words_done_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and state-decoded port strobes; write data flows straight from DM.
  always_comb begin
    state_d    = state_q;
    busy       = 1'b0;
    done       = 1'b0;
    DM_enable  = 1'b0;
    DM_read    = 1'b0;
    DM_address = '0;
    MEM_en     = 1'b0;
    MEM_write  = 1'b0;
    MEM_addr   = '0;
    MEM_Din    = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (length == '0) ? DONE : RD;
        end
      end
      RD: begin
        busy       = 1'b1;
        DM_enable  = 1'b1;
        DM_read    = 1'b1;
        DM_address = src_ptr_q;
        state_d    = WR;
      end
      WR: begin
        busy       = 1'b1;
        DM_address = src_ptr_q;
        MEM_en     = 1'b1;
        MEM_write  = 1'b1;
        MEM_addr   = dst_ptr_q;
        MEM_Din    = DM_out;
        state_d    = (remaining_q == CntW'(1)) ? DONE : RD;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pointers and counters: load on accepted start, advance (wrapping) after each write.
  always_ff @(posedge clk) begin
    if (rst) begin
      src_ptr_q    <= '0;
      dst_ptr_q    <= '0;
      remaining_q  <= '0;
      words_done_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            src_ptr_q    <= src_base;
            dst_ptr_q    <= dst_base;
            remaining_q  <= length;
            words_done_q <= '0;
          end
        end
        WR: begin
          src_ptr_q    <= src_ptr_q + DMAddrSize'(1);
          dst_ptr_q    <= dst_ptr_q + MEMSize'(1);
          remaining_q  <= remaining_q - CntW'(1);
          words_done_q <= words_done_q + CntW'(1);
        end
        default: ;
      endcase
    end
  end

  assign words_done = words_done_q;
  assign DM_write   = 1'b0;
  assign MEM_read   = 1'b0;

endmodule
